// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the byte-serial memory controller between the icache (fetch) and
//   the LSB (load/store). One request is latched at a time and held on the
//   controller until it completes. The result is then returned with a
//   one-cycle done pulse to whichever requester owns the transaction.
//   The LSB has priority. A streak counter forces an icache grant after
//   STARVE_LIMIT back-to-back LSB grants taken while the icache was waiting.
//
// Ports
//   clk_in, rst_in (sync, active-low), rdy_in (0 = freeze), flush_in
//   ic_req_in / ic_addr_in                     -> ic_done_out / ic_data_out
//   lsb_req_in / lsb_addr_in / lsb_data_in /
//   lsb_r_nw_in / lsb_type_in                  -> lsb_done_out / lsb_data_out
//   mc_activate_out / mc_addr_out / mc_data_out /
//   mc_r_nw_out / mc_type_out                  <- mc_data_in / mc_done_in
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | arbitrate; latch the winner's payload into mc_*
// S_BUSY | controller active; wait for mc_done_in
// S_RESP | owner's done pulse is visible for this cycle
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int STREAK_W     = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        ic_req_in,
    input  logic [31:0] ic_addr_in,
    output logic        ic_done_out,
    output logic [31:0] ic_data_out,
    input  logic        lsb_req_in,
    input  logic [31:0] lsb_addr_in,
    input  logic [31:0] lsb_data_in,
    input  logic        lsb_r_nw_in,
    input  logic [2:0]  lsb_type_in,
    output logic        lsb_done_out,
    output logic [31:0] lsb_data_out,
    output logic        mc_activate_out,
    output logic [31:0] mc_addr_out,
    output logic [31:0] mc_data_out,
    output logic        mc_r_nw_out,
    output logic [2:0]  mc_type_out,
    input  logic [31:0] mc_data_in,
    input  logic        mc_done_in
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_LSB} owner_t;

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    state_t              state;
    owner_t              owner;
    logic [STREAK_W-1:0] streak;
    logic                ic_killed;

    logic ic_eligible;
    logic pick_ic;

    assign ic_eligible = ic_req_in & ~flush_in;
    assign pick_ic     = ic_eligible & (~lsb_req_in | (streak == LIMIT));

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state           <= S_IDLE;
            owner           <= OWN_NONE;
            streak          <= '0;
            ic_killed       <= 1'b0;
            ic_done_out     <= 1'b0;
            ic_data_out     <= '0;
            lsb_done_out    <= 1'b0;
            lsb_data_out    <= '0;
            mc_activate_out <= 1'b0;
            mc_addr_out     <= '0;
            mc_data_out     <= '0;
            mc_r_nw_out     <= 1'b1;
            mc_type_out     <= '0;
        end else if (rdy_in) begin
            case (state)
                S_IDLE: begin
                    if (pick_ic) begin
                        owner           <= OWN_IC;
                        ic_killed       <= 1'b0;
                        streak          <= '0;
                        mc_activate_out <= 1'b1;
                        mc_addr_out     <= ic_addr_in;
                        mc_data_out     <= '0;
                        mc_r_nw_out     <= 1'b1;
                        mc_type_out     <= 3'b000;
                        state           <= S_BUSY;
                    end else if (lsb_req_in) begin
                        owner           <= OWN_LSB;
                        ic_killed       <= 1'b0;
                        // Only count grants that actually made the icache wait.
                        if (!ic_req_in)
                            streak <= '0;
                        else if (streak != LIMIT)
                            streak <= streak + STREAK_W'(1);
                        mc_activate_out <= 1'b1;
                        mc_addr_out     <= lsb_addr_in;
                        mc_data_out     <= lsb_data_in;
                        mc_r_nw_out     <= lsb_r_nw_in;
                        mc_type_out     <= lsb_type_in;
                        state           <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // The controller cannot be aborted, so a flushed fetch
                    // still runs to completion; only its result is dropped.
                    if (owner == OWN_IC && flush_in)
                        ic_killed <= 1'b1;
                    if (mc_done_in) begin
                        mc_activate_out <= 1'b0;
                        state           <= S_RESP;
                        if (owner == OWN_IC) begin
                            if (!(ic_killed || flush_in)) begin
                                ic_done_out <= 1'b1;
                                ic_data_out <= mc_data_in;
                            end
                        end else begin
                            lsb_done_out <= 1'b1;
                            lsb_data_out <= mc_r_nw_out ? mc_data_in : 32'h0;
                        end
                    end
                end
                S_RESP: begin
                    ic_done_out  <= 1'b0;
                    ic_data_out  <= '0;
                    lsb_done_out <= 1'b0;
                    lsb_data_out <= '0;
                    owner        <= OWN_NONE;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
